// File: rtl/debug_sequencer_pkg.sv
// Shared types and constants for the debug sequencer: FSM states, command codes and widths.
package debug_sequencer_pkg;

   localparam int unsigned CountWidth  = 32;
   localparam int unsigned RegSelWidth = 5;

   typedef enum logic [2:0] {
      StIdle,
      StRun,
      StStep,
      StHalted,
      StDumpAddr,
      StDumpSend,
      StDumpCyc
   } state_e;

   typedef enum logic [1:0] {
      CmdNop  = 2'b00,
      CmdRun  = 2'b01,
      CmdStep = 2'b10,
      CmdDump = 2'b11
   } cmd_e;

   function automatic logic is_pipe_state(state_e s);
      return (s == StRun) || (s == StStep);
   endfunction

endpackage

// File: rtl/debug_sequencer_cycle_counter.sv
// Saturating counter of enabled pipeline cycles; sticks at all-ones instead of wrapping.
module debug_sequencer_cycle_counter
   import debug_sequencer_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  enable_i,
   output logic [CountWidth-1:0] count_o
);

   logic [CountWidth-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (enable_i && (count_q != '1)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/debug_sequencer.sv
// Debug sequencer: run/step control of the pipeline and a register-bank dump streamed to a sink.
module debug_sequencer
   import debug_sequencer_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned NREGS      = 32
) (
   input  logic                   i_clock,
   input  logic                   i_reset,
   input  logic                   i_cmd_valid,
   input  logic [1:0]             i_cmd,
   output logic                   o_cmd_ready,
   input  logic                   i_halt,
   output logic                   o_pipe_enable,
   output logic                   o_dbg_select,
   output logic [RegSelWidth-1:0] o_dbg_reg_sel,
   input  logic [DATA_WIDTH-1:0]  i_dbg_regdata,
   output logic [DATA_WIDTH-1:0]  o_tx_data,
   output logic                   o_tx_valid,
   input  logic                   i_tx_ready,
   output logic [CountWidth-1:0]  o_cycle_count,
   output logic                   o_halted,
   input  logic [RegSelWidth-1:0] i_instr_rs,   // instruction[25:21] from decode
   output logic [RegSelWidth-1:0] o_rs_addr
);

   localparam logic [RegSelWidth-1:0] LastIdx = RegSelWidth'(NREGS - 1);

   state_e                  state_q, state_d;
   state_e                  ret_q, ret_d;
   logic [RegSelWidth-1:0]  index_q, index_d;
   logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
   logic                    pipe_en_q;
   cmd_e                    cmd;
   logic                    cmd_fire;
   logic                    tx_fire;

   assign cmd      = cmd_e'(i_cmd);
   assign cmd_fire = i_cmd_valid && o_cmd_ready;
   assign tx_fire  = o_tx_valid && i_tx_ready;

   always_comb begin
      state_d   = state_q;
      ret_d     = ret_q;
      index_d   = index_q;
      tx_data_d = tx_data_q;
      case (state_q)
         StIdle: begin
            if (cmd_fire) begin
               unique case (cmd)
                  CmdRun:  state_d = StRun;
                  CmdStep: state_d = StStep;
                  CmdDump: begin
                     state_d = StDumpAddr;
                     ret_d   = StIdle;
                     index_d = '0;
                  end
                  CmdNop:  state_d = StIdle;
               endcase
            end
         end
         StHalted: begin
            // Run and step are swallowed here; only a dump leaves HALTED.
            if (cmd_fire && (cmd == CmdDump)) begin
               state_d = StDumpAddr;
               ret_d   = StHalted;
               index_d = '0;
            end
         end
         StRun: begin
            if (i_halt) begin
               state_d = StHalted;
            end
         end
         StStep: begin
            state_d = i_halt ? StHalted : StIdle;
         end
         StDumpAddr: begin
            tx_data_d = i_dbg_regdata;
            state_d   = StDumpSend;
         end
         StDumpSend: begin
            if (tx_fire) begin
               if (index_q == LastIdx) begin
                  tx_data_d = DATA_WIDTH'(o_cycle_count);
                  state_d   = StDumpCyc;
               end else begin
                  index_d = index_q + 1'b1;
                  state_d = StDumpAddr;
               end
            end
         end
         StDumpCyc: begin
            if (tx_fire) begin
               state_d = ret_q;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q   <= StIdle;
         ret_q     <= StIdle;
         index_q   <= '0;
         tx_data_q <= '0;
         pipe_en_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ret_q     <= ret_d;
         index_q   <= index_d;
         tx_data_q <= tx_data_d;
         pipe_en_q <= is_pipe_state(state_d);
      end
   end

   assign o_cmd_ready   = (state_q == StIdle) || (state_q == StHalted);
   assign o_pipe_enable = pipe_en_q;
   assign o_halted      = (state_q == StHalted);
   assign o_dbg_select  = (state_q == StDumpAddr) || (state_q == StDumpSend);
   assign o_dbg_reg_sel = index_q;
   assign o_tx_valid    = (state_q == StDumpSend) || (state_q == StDumpCyc);
   assign o_tx_data     = tx_data_q;
   assign o_rs_addr     = o_dbg_select ? o_dbg_reg_sel : i_instr_rs;

   debug_sequencer_cycle_counter u_cycle_counter (
      .clk_i    (i_clock),
      .rst_i    (i_reset),
      .enable_i (o_pipe_enable),
      .count_o  (o_cycle_count)
   );

endmodule

// File: tb/tb_debug_sequencer.sv
// Bench for debug_sequencer: queue-based behavioural model checked every cycle plus directed literals.
module tb_debug_sequencer;
   import debug_sequencer_pkg::*;

   localparam int unsigned DW = 32;
   localparam int unsigned NR = 32;

   logic          i_clock = 1'b0;
   logic          i_reset;
   logic          i_cmd_valid;
   logic [1:0]    i_cmd;
   logic          o_cmd_ready;
   logic          i_halt;
   logic          o_pipe_enable;
   logic          o_dbg_select;
   logic [4:0]    o_dbg_reg_sel;
   logic [DW-1:0] i_dbg_regdata;
   logic [DW-1:0] o_tx_data;
   logic          o_tx_valid;
   logic          i_tx_ready;
   logic [31:0]   o_cycle_count;
   logic          o_halted;
   logic [4:0]    i_instr_rs;
   logic [4:0]    o_rs_addr;

   logic [DW-1:0] bank [NR];

   debug_sequencer #(
      .DATA_WIDTH (DW),
      .NREGS      (NR)
   ) dut (
      .i_clock       (i_clock),
      .i_reset       (i_reset),
      .i_cmd_valid   (i_cmd_valid),
      .i_cmd         (i_cmd),
      .o_cmd_ready   (o_cmd_ready),
      .i_halt        (i_halt),
      .o_pipe_enable (o_pipe_enable),
      .o_dbg_select  (o_dbg_select),
      .o_dbg_reg_sel (o_dbg_reg_sel),
      .i_dbg_regdata (i_dbg_regdata),
      .o_tx_data     (o_tx_data),
      .o_tx_valid    (o_tx_valid),
      .i_tx_ready    (i_tx_ready),
      .o_cycle_count (o_cycle_count),
      .o_halted      (o_halted),
      .i_instr_rs    (i_instr_rs),
      .o_rs_addr     (o_rs_addr)
   );

   always #5 i_clock = ~i_clock;

   // Register-file read port behind the rs mux.
   assign i_dbg_regdata = bank[o_rs_addr];

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: pending run/step, resting-halted flag, and the queue of words a dump still owes.
   bit            m_known, m_run, m_step, m_halted, m_dump, m_gap, m_ret_halted;
   logic [31:0]   m_count;
   logic [DW-1:0] m_q [$];
   logic [DW-1:0] got [$];
   bit            prev_valid;
   logic [DW-1:0] prev_data;

   initial begin
      bit            s_reset, s_cmd_valid, s_halt, s_tx_ready, pipe, sel;
      logic [1:0]    s_cmd;
      logic [DW-1:0] dropped;
      m_known    = 0;
      prev_valid = 0;
      forever begin
         @(posedge i_clock);
         s_reset     = i_reset;
         s_cmd_valid = i_cmd_valid;
         s_cmd       = i_cmd;
         s_halt      = i_halt;
         s_tx_ready  = i_tx_ready;
         if (m_known && !s_reset && prev_valid && s_tx_ready) got.push_back(prev_data);
         if (s_reset) begin
            m_known = 1; m_run = 0; m_step = 0; m_halted = 0; m_dump = 0; m_gap = 0;
            m_count = '0;
            m_q.delete();
         end else if (m_known) begin
            pipe = m_run || m_step;
            if (pipe && m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
            if (m_step) begin
               m_step   = 0;
               m_halted = s_halt;
            end else if (m_run) begin
               if (s_halt) begin
                  m_run    = 0;
                  m_halted = 1;
               end
            end else if (m_dump) begin
               if (m_gap) begin
                  m_gap = 0;
               end else if (s_tx_ready) begin
                  dropped = m_q.pop_front();
                  if (m_q.size() == 0) begin
                     m_dump   = 0;
                     m_halted = m_ret_halted;
                  end else if (m_q.size() > 1) begin
                     m_gap = 1;
                  end
               end
            end else if (s_cmd_valid) begin
               if (s_cmd == CmdDump) begin
                  m_dump       = 1;
                  m_gap        = 1;
                  m_ret_halted = m_halted;
                  m_halted     = 0;
                  m_q.delete();
                  for (int i = 0; i < NR; i++) m_q.push_back(bank[i]);
                  m_q.push_back(m_count);
               end else if (!m_halted && s_cmd == CmdRun) begin
                  m_run = 1;
               end else if (!m_halted && s_cmd == CmdStep) begin
                  m_step = 1;
               end
            end
         end
         #1;
         if (m_known) begin
            pipe = m_run || m_step;
            sel  = m_dump && (m_q.size() > 1);
            chk("pipe_enable", o_pipe_enable, pipe);
            chk("cmd_ready", o_cmd_ready, !pipe && !m_dump);
            chk("halted", o_halted, m_halted);
            chk("tx_valid", o_tx_valid, m_dump && !m_gap);
            chk("dbg_select", o_dbg_select, sel);
            chk("cycle_count", o_cycle_count, m_count);
            if (sel) chk("dbg_reg_sel", o_dbg_reg_sel, NR + 1 - m_q.size());
            chk("rs_addr", o_rs_addr, sel ? 5'(NR + 1 - m_q.size()) : i_instr_rs);
            if (m_dump && !m_gap) chk("tx_data", o_tx_data, m_q[0]);
         end
         prev_valid = o_tx_valid;
         prev_data  = o_tx_data;
      end
   end

   task automatic issue(input logic [1:0] c);
      i_cmd_valid = 1'b1;
      i_cmd       = c;
      @(negedge i_clock);
      i_cmd_valid = 1'b0;
      i_cmd       = 2'b00;
   endtask

   task automatic wait_dump_done(input int max_cycles);
      bit done = 0;
      for (int n = 0; n < max_cycles && !done; n++) begin
         @(negedge i_clock);
         done = !m_dump;
      end
      chk("dump_completes", done, 1);
   endtask

   task automatic wait_word(input int w, input int max_cycles);
      bit found = 0;
      for (int n = 0; n < max_cycles && !found; n++) begin
         if (m_dump && !m_gap && m_q.size() == NR + 1 - w) found = 1;
         else @(negedge i_clock);
      end
      chk("word_reached", found, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < NR; i++) bank[i] = DW'(i * 32'h11);
      i_reset     = 1'b1;
      i_cmd_valid = 1'b0;
      i_cmd       = 2'b00;
      i_halt      = 1'b0;
      i_tx_ready  = 1'b1;
      i_instr_rs  = 5'd9;
      repeat (2) @(negedge i_clock);
      i_reset = 1'b0;
      chk("rst_cmd_ready", o_cmd_ready, 1);
      chk("rst_pipe", o_pipe_enable, 0);
      chk("rst_select", o_dbg_select, 0);
      chk("rst_reg_sel", o_dbg_reg_sel, 0);
      chk("rst_tx_valid", o_tx_valid, 0);
      chk("rst_tx_data", o_tx_data, 0);
      chk("rst_count", o_cycle_count, 0);
      chk("rst_halted", o_halted, 0);

      // Three single steps from IDLE.
      for (int k = 0; k < 3; k++) begin
         issue(CmdStep);
         chk("step_pulse_hi", o_pipe_enable, 1);
         @(negedge i_clock);
         chk("step_pulse_lo", o_pipe_enable, 0);
      end
      chk("step_count", o_cycle_count, 3);
      chk("step_idle_ready", o_cmd_ready, 1);
      chk("step_not_halted", o_halted, 0);

      issue(CmdNop);
      chk("nop_pipe", o_pipe_enable, 0);
      i_instr_rs = 5'd21;
      i_halt = 1'b1;
      repeat (2) @(negedge i_clock);
      i_halt = 1'b0;
      chk("idle_halt_ignored", o_halted, 0);
      chk("rs_addr_instr", o_rs_addr, 21);

      i_reset = 1'b1;
      @(negedge i_clock);
      i_reset = 1'b0;
      chk("reset_count", o_cycle_count, 0);

      // Run, halting on the tenth enabled cycle.
      issue(CmdRun);
      for (int i = 1; i <= 10; i++) begin
         chk("run_enable", o_pipe_enable, 1);
         chk("run_count", o_cycle_count, i - 1);
         i_halt = (i == 10);
         @(negedge i_clock);
      end
      i_halt = 1'b0;
      chk("halt_pipe_off", o_pipe_enable, 0);
      chk("halt_count", o_cycle_count, 10);
      chk("halt_flag", o_halted, 1);

      // Run and step are swallowed while halted.
      i_halt = 1'b1;
      issue(CmdRun);
      chk("halted_run_pipe", o_pipe_enable, 0);
      chk("halted_run_ready", o_cmd_ready, 1);
      issue(CmdStep);
      @(negedge i_clock);
      chk("halted_step_pipe", o_pipe_enable, 0);
      chk("halted_count", o_cycle_count, 10);
      chk("halted_stays", o_halted, 1);

      // Full dump at full rate from HALTED.
      got.delete();
      issue(CmdDump);
      wait_dump_done(200);
      i_halt = 1'b0;
      chk("dump1_words", got.size(), NR + 1);
      if (got.size() == NR + 1) begin
         chk("dump1_r0", got[0], 32'h0);
         chk("dump1_r1", got[1], 32'h11);
         chk("dump1_r31", got[31], 32'h20F);
         chk("dump1_count", got[32], 32'd10);
      end
      chk("dump1_return_halted", o_halted, 1);

      // Backpressure on word 7.
      got.delete();
      issue(CmdDump);
      wait_word(7, 100);
      i_tx_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         chk("stall_data", o_tx_data, 32'h77);
         chk("stall_valid", o_tx_valid, 1);
         @(negedge i_clock);
      end
      i_tx_ready = 1'b1;
      wait_dump_done(200);
      chk("dump2_words", got.size(), NR + 1);
      if (got.size() == NR + 1) begin
         chk("dump2_r6", got[6], 32'h66);
         chk("dump2_r7", got[7], 32'h77);
         chk("dump2_r8", got[8], 32'h88);
      end

      // Reset in the middle of a dump, then a fresh dump from IDLE.
      issue(CmdDump);
      wait_word(12, 100);
      i_reset = 1'b1;
      @(negedge i_clock);
      i_reset = 1'b0;
      chk("mid_rst_valid", o_tx_valid, 0);
      chk("mid_rst_ready", o_cmd_ready, 1);
      chk("mid_rst_count", o_cycle_count, 0);
      chk("mid_rst_select", o_dbg_select, 0);
      got.delete();
      issue(CmdDump);
      wait_dump_done(200);
      chk("dump3_words", got.size(), NR + 1);
      if (got.size() == NR + 1) begin
         chk("dump3_r0", got[0], 32'h0);
         chk("dump3_count", got[32], 32'h0);
      end
      chk("dump3_return_idle", o_halted, 0);

      // A step that sees halt lands in HALTED.
      issue(CmdStep);
      i_halt = 1'b1;
      @(negedge i_clock);
      i_halt = 1'b0;
      chk("step_halt_flag", o_halted, 1);
      chk("step_halt_count", o_cycle_count, 1);
      repeat (2) @(negedge i_clock);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
